// File: rtl/fir_tap_ctrl.sv
// Tap-address sequencer for the FIR delay line: handshakes one sample in, sweeps taps newest→oldest, then holds result-valid.
// Optional FIR_TAP_CTRL_OVERLAP_EN lets a new sample be accepted in the same cycle the result is taken.
module fir_tap_ctrl #(
  parameter int dataWidth = 16,
  parameter int size      = 64,
  localparam int AW       = $clog2(size)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] taps_m1,
  output logic          sr_shift,
  output logic [AW-1:0] sr_address,
  output logic          mac_en,
  output logic          mac_first,
  output logic          mac_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t        state, state_d;
  logic [AW-1:0] cnt, cnt_d;
  logic [AW-1:0] last_q, last_d;
  logic [AW-1:0] taps_lim;

  // dataWidth only documents the attached delay line; reject nonsense configurations at elaboration.
  if (dataWidth < 1 || size < 2) begin : g_bad_param
    $error("fir_tap_ctrl: dataWidth must be >= 1 and size >= 2");
  end

  // Clamping is only needed when the address field can encode taps beyond the delay-line depth.
  if (size < (2 ** AW)) begin : g_clamp
    assign taps_lim = (taps_m1 > AW'(size - 1)) ? AW'(size - 1) : taps_m1;
  end else begin : g_pass
    assign taps_lim = taps_m1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      last_q <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      last_q <= last_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    last_d     = last_q;
    in_ready   = 1'b0;
    sr_shift   = 1'b0;
    sr_address = '0;
    mac_en     = 1'b0;
    mac_first  = 1'b0;
    mac_last   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        sr_shift = in_valid;
        if (in_valid) begin
          last_d  = taps_lim;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        sr_address = cnt;
        mac_en     = 1'b1;
        mac_first  = (cnt == '0);
        mac_last   = (cnt == last_q);
        // cnt parks on the final tap so DONE keeps presenting the last address.
        if (cnt == last_q) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      DONE: begin
        out_valid  = 1'b1;
        sr_address = cnt;
`ifdef FIR_TAP_CTRL_OVERLAP_EN
        in_ready = out_ready;
        sr_shift = in_valid & out_ready;
        if (out_ready) begin
          if (in_valid) begin
            last_d  = taps_lim;
            cnt_d   = '0;
            state_d = SCAN;
          end else begin
            state_d = IDLE;
          end
        end
`else
        if (out_ready) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    // The handshake outputs must stay low for as long as reset is held.
    if (rst) begin
      in_ready = 1'b0;
      sr_shift = 1'b0;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_fir_tap_ctrl.sv
// Randomized bench for fir_tap_ctrl against a frame-level reference model (tap index within frame, frame length).
// Honours FIR_TAP_CTRL_OVERLAP_EN when the design is built with it.
module tb_fir_tap_ctrl;

  localparam int AW = 6;
`ifdef FIR_TAP_CTRL_OVERLAP_EN
  localparam bit overlap = 1'b1;
`else
  localparam bit overlap = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] taps_m1;
  logic          sr_shift;
  logic [AW-1:0] sr_address;
  logic          mac_en;
  logic          mac_first;
  logic          mac_last;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // Reference model: is a frame in progress, which tap index (1-based) it is at, and how many taps it has.
  bit m_active = 1'b0;
  int m_k      = 0;
  int m_n      = 0;

  fir_tap_ctrl #(.dataWidth(16), .size(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .taps_m1   (taps_m1),
    .sr_shift  (sr_shift),
    .sr_address(sr_address),
    .mac_en    (mac_en),
    .mac_first (mac_first),
    .mac_last  (mac_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", tag, $time, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_in_ready"}, 32'(in_ready), 0);
    checkOutput({tag, "_sr_shift"}, 32'(sr_shift), 0);
    checkOutput({tag, "_sr_address"}, 32'(sr_address), 0);
    checkOutput({tag, "_mac_en"}, 32'(mac_en), 0);
    checkOutput({tag, "_mac_first"}, 32'(mac_first), 0);
    checkOutput({tag, "_mac_last"}, 32'(mac_last), 0);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 0);
    checkOutput({tag, "_busy"}, 32'(busy), 0);
  endtask

  // One clock cycle: drive inputs, compare against the model mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input logic iv, input logic [AW-1:0] tp, input logic ordy);
    int e_ready, e_shift, e_addr, e_en, e_first, e_last, e_ov, e_busy;
    in_valid  = iv;
    taps_m1   = tp;
    out_ready = ordy;
    e_ready = 0; e_shift = 0; e_addr = 0; e_en = 0;
    e_first = 0; e_last = 0; e_ov = 0; e_busy = 0;
    if (!m_active) begin
      e_ready = 1;
      e_shift = int'(iv);
    end else if (m_k <= m_n) begin
      e_busy  = 1;
      e_en    = 1;
      e_addr  = m_k - 1;
      e_first = int'(m_k == 1);
      e_last  = int'(m_k == m_n);
    end else begin
      e_busy = 1;
      e_ov   = 1;
      e_addr = m_n - 1;
      if (overlap) begin
        e_ready = int'(ordy);
        e_shift = int'(iv & ordy);
      end
    end
    @(negedge clk);
    checkOutput("in_ready", 32'(in_ready), 32'(e_ready));
    checkOutput("sr_shift", 32'(sr_shift), 32'(e_shift));
    checkOutput("sr_address", 32'(sr_address), 32'(e_addr));
    checkOutput("mac_en", 32'(mac_en), 32'(e_en));
    checkOutput("mac_first", 32'(mac_first), 32'(e_first));
    checkOutput("mac_last", 32'(mac_last), 32'(e_last));
    checkOutput("out_valid", 32'(out_valid), 32'(e_ov));
    checkOutput("busy", 32'(busy), 32'(e_busy));
    @(posedge clk);
    if (!m_active) begin
      if (iv) begin
        m_active = 1'b1;
        m_k      = 1;
        m_n      = int'(tp) + 1;
      end
    end else if (m_k <= m_n) begin
      m_k++;
    end else if (ordy) begin
      if (overlap && iv) begin
        m_k = 1;
        m_n = int'(tp) + 1;
      end else begin
        m_active = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    taps_m1   = 6'd5;
    out_ready = 1'b1;
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // First cycle after release, then the basic 4-tap frame with out_ready high.
    applyStimulus(1'b0, 6'd3, 1'b1);
    applyStimulus(1'b1, 6'd3, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 6'd3, 1'b1);

    // Single-tap frame.
    applyStimulus(1'b1, 6'd0, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 6'd0, 1'b1);

    // Full-depth frame with in_valid held and the consumer stalling for 10 cycles.
    applyStimulus(1'b1, 6'd63, 1'b0);
    for (int i = 0; i < 74; i++) applyStimulus(1'b1, 6'(i), 1'b0);
    applyStimulus(1'b1, 6'd2, 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 6'd2, 1'b1);

    // Abort mid-sweep at address 17 while taps_m1 keeps changing.
    applyStimulus(1'b1, 6'd40, 1'b1);
    for (int i = 0; i < 17; i++) applyStimulus(1'b0, 6'($urandom_range(0, 63)), 1'b1);
    checkOutput("pre_abort_address", 32'(sr_address), 17);
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("abort");
    @(posedge clk);
    #1;
    rst      = 1'b0;
    m_active = 1'b0;
    applyStimulus(1'b1, 6'd2, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 6'd2, 1'b1);

    // Random traffic; taps_m1 moves every cycle so mid-frame changes are exercised throughout.
    for (int i = 0; i < 800; i++) begin
      logic [AW-1:0] tp;
      int sel;
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      tp = 6'd0;
      else if (sel == 1) tp = 6'd63;
      else               tp = 6'($urandom_range(0, 7));
      applyStimulus(logic'(($urandom % 4) != 0), tp, logic'(($urandom % 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fir_tap_ctrl.md
# fir_tap_ctrl

Sequencer for the 16-bit, 64-entry addressable delay line in the FIR datapath. It accepts one input sample per valid/ready handshake and pulses the delay line's shift strobe. It then sweeps the tap address from newest to oldest sample while driving MAC enable, first and last strobes, and finally holds a result-valid flag until the downstream consumer accepts it. The block sits between the sample source, the delay line and the MAC unit; it carries no sample data itself.

## Interface
- `dataWidth`, 16: width of delay-line samples; informational only, no logic depends on it.
- `size`, 64: delay-line depth; `AW = $clog2(size)`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: source has a sample on the delay-line `din` bus.
- `in_ready` out 1: controller accepts a sample this cycle.
- `taps_m1` in AW: number of taps minus one; sampled at the input handshake.
- `sr_shift` out 1: delay-line shift strobe.
- `sr_address` out AW: delay-line tap address; 0 selects the newest sample.
- `mac_en` out 1: MAC consumes the delay-line output this cycle.
- `mac_first` out 1: MAC loads the product instead of accumulating.
- `mac_last` out 1: final tap of the frame.
- `out_valid` out 1: accumulated result is complete.
- `out_ready` in 1: consumer accepts the result.
- `busy` out 1: state is not IDLE.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE:
  - `in_ready=1`, and `sr_shift = in_valid`, combinational.
  - On `in_valid`: latch `taps_m1` into `last_q`, clear tap counter `cnt` to 0, go to SCAN.
- SCAN:
  - `sr_address=cnt`, `mac_en=1`, `mac_first=(cnt==0)`, `mac_last=(cnt==last_q)`.
  - `cnt` increments each cycle.
  - When `cnt==last_q`, go to DONE.
  - `in_valid` is ignored and `in_ready=0`.
- DONE:
  - `out_valid=1`, held until `out_ready`; then go to IDLE.
  - `sr_address` holds its last value.
- `sr_address` is 0 in IDLE.
- `mac_en`, `mac_first` and `mac_last` are 0 outside SCAN.
- `taps_m1` changes outside the handshake cycle have no effect on the current frame.
- `taps_m1=0` gives a single SCAN cycle with `mac_first` and `mac_last` both high.
- No wrap: `cnt` never exceeds `last_q`, so `sr_address` stays within `0..size-1`. A `taps_m1` value ≥ `size` (non-power-of-two `size`) is clamped to `size-1` at latch time.

## Timing
- Reset values while `rst` is high: state IDLE, `cnt=0`, `last_q=0`, and every output 0, including `in_ready` and `busy`.
- `in_ready` rises in the first cycle after `rst` deasserts.
- `rst` asserted mid-SCAN or mid-DONE aborts the frame immediately with no `out_valid`. Delay-line contents are not touched by this block.
- Let N = `taps_m1 + 1`. Handshake in cycle c0 (delay line shifts at the end of c0).
  - SCAN occupies cycles c1..cN with addresses 0..N-1.
  - `out_valid` is first high in cycle cN+1.
- Minimum sample period: N+2 cycles (IDLE, N SCAN cycles, DONE) when `out_ready` is held high.
- All state and registered outputs update on the rising edge of `clk`.
- `sr_shift` and `in_ready` are combinational from state and `in_valid`.

## Configuration
- `FIR_TAP_CTRL_OVERLAP_EN` defined:
  - In DONE, `in_ready = out_ready` and `sr_shift = in_valid & out_ready`.
  - If both handshakes occur in the same cycle, the controller latches `taps_m1`, clears `cnt` and goes directly to SCAN.
  - Minimum sample period becomes N+1 cycles.
- Undefined: `in_ready=0` in DONE; a new sample is accepted only in IDLE.

## Test plan
- Reset, then release: all outputs 0 during `rst`; `in_ready=1` and `busy=0` the cycle after release.
- `taps_m1=3`, one `in_valid` pulse, `out_ready=1`:
  - `sr_shift` high for 1 cycle.
  - SCAN addresses 0,1,2,3 with `mac_first` on address 0 and `mac_last` on address 3.
  - `out_valid` high for 1 cycle, 5 cycles after the handshake.
- `taps_m1=0`: a single SCAN cycle with `sr_address=0` and `mac_first`, `mac_last`, `mac_en` all high; `out_valid` the next cycle.
- `taps_m1=63`, `out_ready=0` for 10 cycles after `out_valid`:
  - `out_valid` held for those 10 cycles.
  - `in_valid` held high throughout produces no `sr_shift` until back in IDLE (or, with `FIR_TAP_CTRL_OVERLAP_EN`, exactly in the `out_ready` cycle).
- Assert `rst` during SCAN at address 17: outputs 0 asynchronously and no `out_valid`; the next frame starts cleanly at address 0.
- `taps_m1` changed in the middle of SCAN: the sweep length is unchanged.
